key_repeater: RTL and testbench
===============================

// Module: key_repeater
//
// PURPOSE
//   Turns a debounced, active-high button level into discrete key events:
//   one press pulse, auto-repeat pulses while the button is held, and one
//   release pulse. Sits between a debouncer and the sequence-acceptor logic.
//   The downstream logic only ever sees single-cycle events, never levels.
//
// PARAMETERS
//   CNT_W  16     width of the internal delay/rate counter
//   DELAY  50000  cycles from the press pulse to the first repeat pulse;
//                 legal range 1 .. 2**CNT_W-1
//   RATE   10000  cycles between successive repeat pulses;
//                 legal range 1 .. 2**CNT_W-1
//
// PORTS
//   clk        in   1  clock
//   reset_     in   1  asynchronous, active-low reset
//   debounced  in   1  steady button level, synchronous to clk, 1 = pressed
//   enable     in   1  1 = generate events; 0 = suppress all events
//   press      out  1  one-cycle pulse on the press edge
//   repeat     out  1  one-cycle pulse for each auto-repeat
//   release    out  1  one-cycle pulse on the release edge
//   held       out  1  level: high from the press pulse until the release pulse
//
// BEHAVIOUR
//   - Reset values: all outputs 0, state IDLE, counter 0, prev 0.
//     Outputs are registered.
//   - prev: debounced registered every clk, regardless of enable.
//     rise = debounced & ~prev; fall = ~debounced & prev.
//   - States: IDLE, WAIT (initial delay), RPT (repeating).
//   - Latency: events are evaluated on edge N; the pulse is visible
//     after edge N+1.
//   - IDLE, rise & enable: press=1, held=1, counter<=0, go to WAIT.
//   - WAIT:
//     - counter increments each cycle.
//     - When counter==DELAY-1: repeat=1, counter<=0, go to RPT.
//     - Result: the first repeat pulse appears exactly DELAY cycles after
//       the press pulse.
//   - RPT:
//     - counter increments each cycle.
//     - When counter==RATE-1: repeat=1, counter<=0.
//     - Result: pulses are spaced exactly RATE cycles apart.
//   - WAIT/RPT, fall: release=1, held=0, counter<=0, go to IDLE.
//     - Release has priority over a repeat due in the same cycle; no repeat
//       is emitted.
//   - Pulse overlap: press, repeat and release are mutually exclusive in any
//     cycle. Each pulse is exactly one cycle wide.
//   - enable=0, any state:
//     - Go to IDLE, counter<=0, held<=0, and no pulses, including no release.
//     - prev keeps tracking the input.
//     - Re-enabling while the button is still held gives no press, because
//       no rise is seen; a fresh press is required.
//   - Reset released while debounced=1: prev=0, so the first sampled cycle is
//     a rise. press fires if enable=1.
//   - Counter never wraps: it is cleared on reaching its terminal value, or
//     on leaving WAIT/RPT.
//   - Reset asserted mid-hold: all outputs clear at once (async). No release
//     pulse is generated.
//
// TESTING  (bench parameters: DELAY=4, RATE=3, enable=1 unless stated)
//   1. Tap: debounced high for 2 cycles, then low
//      -> press at t+1, release at t+3; no repeat; held high for 2 cycles.
//   2. Hold 15 cycles
//      -> press at t+1; repeats at t+5, t+8, t+11, t+14; release at t+16.
//   3. Release on the exact cycle a repeat is due (fall when counter==RATE-1)
//      -> only release asserts; repeat stays 0.
//   4. Hold, drop enable for 2 cycles mid-hold, restore while still held
//      -> no pulses and held=0 from the drop; no press on restore; a new
//         press/release then works normally.
//   5. Reset released with debounced=1 -> single press one cycle later.
//      Assert reset_ mid-RPT -> all outputs 0 immediately, state IDLE.
//   6. DELAY=1, RATE=1, hold 5 cycles
//      -> press, then repeat on every following cycle while held;
//         one release at the end.

Source files
------------

// File: rtl/key_repeater.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeater
//  Description : Converts a debounced, active-high button level into
//                single-cycle key events: one press pulse, auto-repeat
//                pulses while the button stays held, and one release pulse.
//                The first repeat fires DELAY cycles after the press, and
//                later repeats follow every RATE cycles. All outputs are
//                registered.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    CNT_W        width of the delay/rate counter
//    DELAY        cycles from press pulse to first repeat (1 .. 2**CNT_W-1)
//    RATE         cycles between repeat pulses           (1 .. 2**CNT_W-1)
//  Ports
//    clk          clock
//    reset_       asynchronous, active-low reset
//    debounced_i  steady button level, synchronous to clk, 1 = pressed
//    enable_i     1 = generate events, 0 = suppress all events
//    press_o      one-cycle pulse on the press edge
//    repeat_o     one-cycle pulse for each auto-repeat
//    release_o    one-cycle pulse on the release edge
//    held_o       level, high from the press pulse until the release pulse
// ============================================================================
module key_repeater #(
    parameter int CNT_W = 16,
    parameter int DELAY = 50000,
    parameter int RATE  = 10000
) (
    input  logic clk,
    input  logic reset_,
    input  logic debounced_i,
    input  logic enable_i,
    output logic press_o,
    output logic repeat_o,
    output logic release_o,
    output logic held_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RPT  = 2'd2
    } state_t;

    // Terminal counts: the counter starts at 0 on entry, so a pulse is due
    // when it reaches N-1, giving exactly N cycles of spacing.
    localparam logic [CNT_W-1:0] c_delay_last = CNT_W'(DELAY - 1);
    localparam logic [CNT_W-1:0] c_rate_last  = CNT_W'(RATE - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               prev_q;
    logic               press_q, press_d;
    logic               repeat_q, repeat_d;
    logic               release_q, release_d;
    logic               held_q, held_d;

    logic               w_rise;
    logic               w_fall;

    assign w_rise = debounced_i & ~prev_q;
    assign w_fall = ~debounced_i & prev_q;

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            press_q   <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            // Edge history tracks the input even while disabled, so that
            // re-enabling during a hold does not look like a fresh press.
            prev_q    <= debounced_i;
            press_q   <= press_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and event decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;

        if (!enable_i) begin
            // Silent abort: no release pulse is produced when disabled.
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = '0;
                    if (w_rise) begin
                        press_d = 1'b1;
                        state_d = ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    // Release wins over a repeat falling due in the same cycle.
                    if (w_fall) begin
                        release_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else if (cnt_q == c_delay_last) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_RPT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                ST_RPT: begin
                    if (w_fall) begin
                        release_d = 1'b1;
                        cnt_d     = '0;
                        state_d   = ST_IDLE;
                    end else if (cnt_q == c_rate_last) begin
                        repeat_d = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        held_d = (state_d != ST_IDLE);
    end

    assign press_o   = press_q;
    assign repeat_o  = repeat_q;
    assign release_o = release_q;
    assign held_o    = held_q;

endmodule
`default_nettype wire

// File: tb/tb_key_repeater.sv
`default_nettype none
// ============================================================================
//  Module      : tb_key_repeater
//  Description : Directed self-checking bench for key_repeater. One instance
//                uses DELAY=4/RATE=3, a second uses DELAY=1/RATE=1; both
//                share all inputs. Expected event cycles are hand-computed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_key_repeater;

    logic clk;
    logic reset_;
    logic deb;
    logic en;

    logic press0, rep0, rel0, held0;
    logic press1, rep1, rel1, held1;

    int n_tests = 0;
    int n_fail  = 0;

    key_repeater #(
        .CNT_W (16),
        .DELAY (4),
        .RATE  (3)
    ) u_dut (
        .clk         (clk),
        .reset_      (reset_),
        .debounced_i (deb),
        .enable_i    (en),
        .press_o     (press0),
        .repeat_o    (rep0),
        .release_o   (rel0),
        .held_o      (held0)
    );

    key_repeater #(
        .CNT_W (16),
        .DELAY (1),
        .RATE  (1)
    ) u_dut1 (
        .clk         (clk),
        .reset_      (reset_),
        .debounced_i (deb),
        .enable_i    (en),
        .press_o     (press1),
        .repeat_o    (rep1),
        .release_o   (rel1),
        .held_o      (held1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs cycles 1..ncyc. Before edge k the button is driven high when
    // k <= hold and enable is dropped where en_off[k] is set. After each
    // edge the {press,repeat,release,held} outputs of the selected instance
    // are compared against the hand-computed event cycles.
    task automatic run_case(input string name, input int which,
                            input int hold, input int ncyc,
                            input logic [31:0] en_off,
                            input int press_c, input logic [31:0] rep_mask,
                            input int rel_c, input int held_end);
        logic [3:0] obs;
        logic [3:0] exp;
        for (int k = 1; k <= ncyc; k++) begin
            deb = (k <= hold);
            en  = ~en_off[k];
            @(posedge clk);
            #1;
            obs = (which == 1) ? {press1, rep1, rel1, held1}
                               : {press0, rep0, rel0, held0};
            exp = {(k == press_c), rep_mask[k], (k == rel_c),
                   (k >= press_c && k < held_end)};
            check_eq($sformatf("%s c%0d", name, k), 32'(obs), 32'(exp));
        end
        en = 1'b1;
    endtask

    initial begin
        reset_ = 1'b0;
        deb    = 1'b0;
        en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset dut0", 32'({press0, rep0, rel0, held0}), 32'h0);
        check_eq("reset dut1", 32'({press1, rep1, rel1, held1}), 32'h0);
        reset_ = 1'b1;
        @(posedge clk);
        #1;

        // 1. Tap: high for 2 cycles
        run_case("tap", 0, 2, 5, 32'h0, 1, 32'h0, 3, 3);

        // 2. Hold 15 cycles: repeats at 5, 8, 11, 14; release at 16
        run_case("hold15", 0, 15, 18, 32'h0, 1,
                 (32'd1 << 5) | (32'd1 << 8) | (32'd1 << 11) | (32'd1 << 14),
                 16, 16);

        // 3. Fall exactly when a repeat is due at cycle 11
        run_case("relprio", 0, 10, 13, 32'h0, 1,
                 (32'd1 << 5) | (32'd1 << 8), 11, 11);

        // 4. Enable dropped for cycles 4-5 mid-hold, restored while held
        run_case("endrop", 0, 9, 12, (32'd1 << 4) | (32'd1 << 5),
                 1, 32'h0, 0, 4);
        run_case("retap", 0, 2, 5, 32'h0, 1, 32'h0, 3, 3);

        // 6. DELAY=1, RATE=1: repeat every cycle after the press
        run_case("fast", 1, 5, 8, 32'h0, 1,
                 (32'd1 << 2) | (32'd1 << 3) | (32'd1 << 4) | (32'd1 << 5),
                 6, 6);

        // 5. Reset released with the button already high, then reset mid-RPT
        deb    = 1'b1;
        reset_ = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_ = 1'b1;
        run_case("rsthi", 0, 7, 7, 32'h0, 1, (32'd1 << 5), 0, 100);
        reset_ = 1'b0;
        #2;
        check_eq("async rst dut0", 32'({press0, rep0, rel0, held0}), 32'h0);
        check_eq("async rst dut1", 32'({press1, rep1, rel1, held1}), 32'h0);
        deb = 1'b0;
        @(posedge clk);
        #1;
        check_eq("in rst", 32'({press0, rep0, rel0, held0}), 32'h0);
        reset_ = 1'b1;
        run_case("posttap", 0, 2, 5, 32'h0, 1, 32'h0, 3, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
